usb_tx_scheduler: RTL and testbench
===================================

// Module: usb_tx_scheduler
// PURPOSE
//  Round-robin scheduler sharing a single USB transmit byte port (tx_data/tx_valid/tx_ready) among
//  NUM_REQ endpoint requesters. Per granted packet it sequences the PID byte, streams the payload
//  from the winning endpoint, and appends the USB CRC16. It then holds an inter-packet gap before re-arbitrating.
//  Sits between endpoint buffers and the serializer FSM that consumes tx_valid/tx_ready.
// PARAMETERS
//  NUM_REQ     2   number of requesting endpoints (2..8)
//  IPG_CYCLES  4   idle clk cycles after CRC_HI accepted before next grant (>=1)
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          synchronous, active-low
//  req        in   NUM_REQ    per-endpoint packet request, held until its done pulse
//  req_pid    in   4*NUM_REQ  per-endpoint 4-bit PID, slice i = [4i+3:4i]
//  req_zlp    in   NUM_REQ    1 = zero-length packet (no payload phase)
//  in_data    in   8*NUM_REQ  per-endpoint payload byte
//  in_valid   in   NUM_REQ    payload byte valid
//  in_last    in   NUM_REQ    qualifies final payload byte
//  in_ready   out  NUM_REQ    payload byte accepted (only granted slice may be 1)
//  grant      out  NUM_REQ    one-hot owner of current packet, 0 when idle
//  tx_data    out  8          byte to serializer
//  tx_valid   out  1          tx_data valid
//  tx_ready   in   1          serializer accepts byte when tx_valid&tx_ready
//  busy       out  1          1 in any state other than IDLE
//  done       out  NUM_REQ    1-cycle pulse on the grant bit when CRC_HI is accepted
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, grant=0, in_ready=0, tx_valid=0, tx_data=0, busy=0,
//    done=0, rr pointer=0 (endpoint 0 highest priority). Reset mid-packet aborts immediately; no CRC is sent.
//  States: IDLE -> PID -> DATA -> CRC_LO -> CRC_HI -> GAP -> IDLE. All outputs are registered.
//  IDLE: if any req, grant the first set bit searching from rr pointer upward with wrap; latch PID and
//    zlp flag; go to PID next cycle. rr pointer = winner+1 (mod NUM_REQ) when the grant is issued.
//  PID: tx_data={~pid,pid}, tx_valid=1. On tx_ready: go to CRC_LO if zlp, else DATA. CRC16 init 0xFFFF.
//  DATA: in_ready[g]=tx_ready (pass-through, zero-bubble); tx_data=in_data[g], tx_valid=in_valid[g].
//    Each accepted byte updates CRC16 (poly 0x8005, LSB-first, reflected). Accepting a byte with
//    in_last=1 goes to CRC_LO. in_valid low = stall, no timeout.
//  CRC_LO/CRC_HI: tx_data = low/high byte of ~crc, tx_valid=1; advance on tx_ready.
//  On CRC_HI accept: done[g]=1 for one cycle, grant cleared, go to GAP.
//  GAP: counts IPG_CYCLES cycles with tx_valid=0, then IDLE. req sampled only in IDLE.
//  tx_valid, once asserted, holds with tx_data stable until accepted (AXI-style, no retraction).
//  req deasserted after grant is ignored; the packet completes. Multiple req in the same cycle: round-robin only.
//  in_ready is never asserted for non-granted endpoints; their in_valid is ignored.
// TESTING
//  1) Ep0 req, PID=0x3, zlp=1, tx_ready=1 -> tx bytes C3,00,00; done[0] pulse; busy low after 4+IPG.
//  2) Ep1 PID=0xB, payload 00 01 02 03 -> tx bytes 4B,00,01,02,03,CRC_LO,CRC_HI. The received
//     CRC check over payload+CRC yields residual 0x800D (bit-reversed 0xB001).
//  3) Both req held continuously -> grants alternate 0,1,0,1; no endpoint is granted twice in a row.
//  4) tx_ready toggling 1/0 each cycle in DATA -> tx_data stable while stalled; no byte lost or duplicated.
//  5) Reset low during DATA byte 2 -> next cycle tx_valid=0, grant=0, busy=0; re-request restarts at PID.
//  6) in_valid gaps of 3 cycles in DATA -> tx_valid low during gaps; CRC is identical to the gap-free run.

Source files
------------

// File: rtl/usb_tx_scheduler_if.sv
// Bundle of endpoint-side and serializer-side signals of the USB transmit scheduler.
// The master modport is the scheduler's view; the slave modport is the endpoints plus serializer.
interface usb_tx_scheduler_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req;
   logic [4*NUM_REQ-1:0] req_pid;
   logic [NUM_REQ-1:0]   req_zlp;
   logic [8*NUM_REQ-1:0] in_data;
   logic [NUM_REQ-1:0]   in_valid;
   logic [NUM_REQ-1:0]   in_last;
   logic [NUM_REQ-1:0]   in_ready;
   logic [NUM_REQ-1:0]   grant;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 busy;
   logic [NUM_REQ-1:0]   done;

   modport master (
      input  req, req_pid, req_zlp, in_data, in_valid, in_last, tx_ready,
      output in_ready, grant, tx_data, tx_valid, busy, done
   );

   modport slave (
      output req, req_pid, req_zlp, in_data, in_valid, in_last, tx_ready,
      input  in_ready, grant, tx_data, tx_valid, busy, done
   );
endinterface

// File: rtl/usb_tx_scheduler.sv
// Round-robin scheduler sharing one USB transmit byte port among NUM_REQ endpoints.
// Each packet is sent as PID, optional payload and CRC16, followed by an inter-packet gap.
module usb_tx_scheduler #(
   parameter int NUM_REQ    = 2,
   parameter int IPG_CYCLES = 4
) (
   input logic                clk,
   input logic                reset,
   usb_tx_scheduler_if.master bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = PTR_W + 1;
   localparam int GAP_W = $clog2(IPG_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PID,
      S_DATA,
      S_CRC_LO,
      S_CRC_HI,
      S_GAP
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [NUM_REQ-1:0] r_grant;
   logic [PTR_W-1:0]   r_gIdx;
   logic [PTR_W-1:0]   r_rrPtr;
   logic [3:0]         r_pid;
   logic               r_zlp;
   logic [15:0]        r_crc;
   logic [GAP_W-1:0]   r_gapCnt;
   logic [NUM_REQ-1:0] r_done;

   logic               w_found;
   logic [PTR_W-1:0]   w_winIdx;
   logic [PTR_W-1:0]   w_nextPtr;
   logic [CW-1:0]      w_cand;
   logic               w_selValid;
   logic               w_selLast;
   logic [7:0]         w_selData;
   logic               w_txValid;
   logic [7:0]         w_txData;
   logic [NUM_REQ-1:0] w_inReady;
   logic               w_dataAccept;

   // USB CRC16 in reflected form: poly 0x8005 becomes 0xA001 shifted right, data LSB first
   function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn, input logic [7:0] dataIn);
      logic [15:0] c;
      c = crcIn;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ dataIn[b]) c = (c >> 1) ^ 16'hA001;
         else                  c = c >> 1;
      end
      return c;
   endfunction

   // Search for the first requester starting at the round-robin pointer, wrapping around
   always_comb begin
      w_found  = 1'b0;
      w_winIdx = '0;
      w_cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_rrPtr} + CW'(k);
         if (w_cand >= CW'(NUM_REQ)) w_cand = w_cand - CW'(NUM_REQ);
         if (!w_found && bus.req[w_cand[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winIdx = w_cand[PTR_W-1:0];
         end
      end
   end

   assign w_nextPtr  = (w_winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : w_winIdx + PTR_W'(1);
   assign w_selValid = bus.in_valid[r_gIdx];
   assign w_selLast  = bus.in_last[r_gIdx];
   assign w_selData  = bus.in_data[{r_gIdx, 3'b000} +: 8];

   assign w_dataAccept = (r_state == S_DATA) && w_selValid && bus.tx_ready;

   always_comb begin
      w_nextState = r_state;
      w_txValid   = 1'b0;
      w_txData    = 8'h00;
      w_inReady   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_nextState = S_PID;
         end
         S_PID: begin
            w_txValid = 1'b1;
            w_txData  = {~r_pid, r_pid};
            if (bus.tx_ready) w_nextState = r_zlp ? S_CRC_LO : S_DATA;
         end
         S_DATA: begin
            // Zero-bubble pass-through: the serializer's ready goes straight to the owner
            w_txValid = w_selValid;
            w_txData  = w_selData;
            w_inReady = r_grant & {NUM_REQ{bus.tx_ready}};
            if (w_dataAccept && w_selLast) w_nextState = S_CRC_LO;
         end
         S_CRC_LO: begin
            w_txValid = 1'b1;
            w_txData  = ~r_crc[7:0];
            if (bus.tx_ready) w_nextState = S_CRC_HI;
         end
         S_CRC_HI: begin
            w_txValid = 1'b1;
            w_txData  = ~r_crc[15:8];
            if (bus.tx_ready) w_nextState = S_GAP;
         end
         S_GAP: begin
            if (r_gapCnt == GAP_W'(IPG_CYCLES - 1)) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_gIdx   <= '0;
         r_rrPtr  <= '0;
         r_pid    <= 4'h0;
         r_zlp    <= 1'b0;
         r_crc    <= 16'hFFFF;
         r_gapCnt <= '0;
         r_done   <= '0;
      end else begin
         r_state <= w_nextState;
         r_done  <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= NUM_REQ'(1) << w_winIdx;
                  r_gIdx  <= w_winIdx;
                  r_rrPtr <= w_nextPtr;
                  r_pid   <= bus.req_pid[{w_winIdx, 2'b00} +: 4];
                  r_zlp   <= bus.req_zlp[w_winIdx];
                  r_crc   <= 16'hFFFF;
               end
            end
            S_DATA: begin
               if (w_dataAccept) r_crc <= crc16Byte(r_crc, w_selData);
            end
            S_CRC_HI: begin
               if (bus.tx_ready) begin
                  r_done   <= r_grant;
                  r_grant  <= '0;
                  r_gapCnt <= '0;
               end
            end
            S_GAP: begin
               r_gapCnt <= r_gapCnt + GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.tx_valid = w_txValid;
   assign bus.tx_data  = w_txData;
   assign bus.in_ready = w_inReady;
   assign bus.grant    = r_grant;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = r_done;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: table of packets checked byte by byte, plus
// hand-written mid-packet reset and round-robin sequences.
module tb_usb_tx_scheduler;
   localparam int NUM_REQ    = 2;
   localparam int IPG_CYCLES = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   usb_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

   usb_tx_scheduler #(.NUM_REQ(NUM_REQ), .IPG_CYCLES(IPG_CYCLES)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int          ep;
      logic [3:0]  pid;
      logic        zlp;
      int          len;
      logic [71:0] payload;
      logic        readyToggle;
      logic        validGaps;
      logic        dropEarly;
      logic [7:0]  expPid;
      logic        crcConst;
      logic [15:0] expCrc;
      int          refIdx;
   } vec_t;

   vec_t        vecs[7];
   logic [15:0] gotCrc[7];
   logic [7:0]  rxBytes[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [15:0] refCrc(input logic [15:0] crcIn, input logic [7:0] dataIn);
      logic [15:0] c;
      c = crcIn;
      for (int b = 0; b < 8; b++) begin
         if (c[0] ^ dataIn[b]) c = (c >> 1) ^ 16'hA001;
         else                  c = c >> 1;
      end
      return c;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one packet from endpoint v.ep while acting as serializer, then check what came out
   task automatic applyStimulus(input int vi);
      vec_t               v;
      int                 ptr, gapLeft, gapCycles, viol, nExp, n;
      logic               doneSeen, prevStall, timedOut;
      logic [7:0]         prevData;
      logic [NUM_REQ-1:0] doneVal, grantVal;
      logic [15:0]        res;
      v = vecs[vi];
      rxBytes.delete();
      ptr = 0; gapLeft = 0; gapCycles = 0; viol = 0;
      doneSeen = 1'b0; prevStall = 1'b0; timedOut = 1'b1; prevData = 8'h00;
      doneVal = '0; grantVal = '0;
      @(negedge clk);
      bus.req = '0;
      bus.req[v.ep] = 1'b1;
      bus.req_pid = '0;
      bus.req_pid[4*v.ep +: 4] = v.pid;
      bus.req_zlp = '0;
      bus.req_zlp[v.ep] = v.zlp;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.tx_ready = v.readyToggle ? ((cyc % 2) == 0) : 1'b1;
         bus.in_data  = {NUM_REQ{8'h5A}};
         bus.in_valid = ~(NUM_REQ'(1) << v.ep);
         bus.in_last  = '0;
         if (ptr < v.len) begin
            bus.in_valid[v.ep] = (gapLeft == 0);
            bus.in_data[8*v.ep +: 8] = v.payload[8*ptr +: 8];
            bus.in_last[v.ep] = (ptr == v.len - 1);
         end
         #1;
         if (prevStall && (!bus.tx_valid || bus.tx_data !== prevData)) viol++;
         if ((bus.in_ready & ~bus.grant) != '0) viol++;
         if (bus.grant != '0) begin
            grantVal = bus.grant;
            if (v.dropEarly) bus.req[v.ep] = 1'b0;
         end
         if (bus.tx_valid && bus.tx_ready) rxBytes.push_back(bus.tx_data);
         prevStall = bus.tx_valid && !bus.tx_ready;
         prevData  = bus.tx_data;
         if (bus.in_ready[v.ep] && bus.in_valid[v.ep]) begin
            ptr++;
            gapLeft = v.validGaps ? 3 : 0;
         end else if (gapLeft > 0) begin
            gapLeft--;
         end
         if (doneSeen) begin
            gapCycles++;
            if (bus.tx_valid) viol++;
            if (!bus.busy) begin
               timedOut = 1'b0;
               break;
            end
         end else if (bus.done != '0) begin
            doneSeen = 1'b1;
            doneVal  = bus.done;
            bus.req[v.ep] = 1'b0;
         end
         @(negedge clk);
      end
      bus.in_valid = '0;
      checkOutput($sformatf("vec%0d timeout", vi), 32'(timedOut), 32'd0);
      checkOutput($sformatf("vec%0d grant", vi), 32'(grantVal), 32'(NUM_REQ'(1) << v.ep));
      checkOutput($sformatf("vec%0d done", vi), 32'(doneVal), 32'(NUM_REQ'(1) << v.ep));
      checkOutput($sformatf("vec%0d gap", vi), 32'(gapCycles), 32'(IPG_CYCLES));
      checkOutput($sformatf("vec%0d protocol", vi), 32'(viol), 32'd0);
      nExp = (v.zlp ? 0 : v.len) + 3;
      n = rxBytes.size();
      checkOutput($sformatf("vec%0d nbytes", vi), 32'(n), 32'(nExp));
      if (n == nExp) begin
         checkOutput($sformatf("vec%0d pid", vi), 32'(rxBytes[0]), 32'(v.expPid));
         for (int i = 0; i < n - 3; i++)
            checkOutput($sformatf("vec%0d data[%0d]", vi, i), 32'(rxBytes[1+i]),
                        32'(v.payload[8*i +: 8]));
         gotCrc[vi] = {rxBytes[n-1], rxBytes[n-2]};
         if (v.crcConst) begin
            checkOutput($sformatf("vec%0d crc", vi), 32'(gotCrc[vi]), 32'(v.expCrc));
         end else begin
            res = 16'hFFFF;
            for (int i = 1; i < n; i++) res = refCrc(res, rxBytes[i]);
            checkOutput($sformatf("vec%0d residual", vi), 32'(res), 32'h0000B001);
         end
         if (v.refIdx >= 0)
            checkOutput($sformatf("vec%0d crc vs vec%0d", vi, v.refIdx), 32'(gotCrc[vi]),
                        32'(gotCrc[v.refIdx]));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int                 ptr, nGrants;
      logic               fired, busyLow;
      logic [NUM_REQ-1:0] prevGrant;
      logic [NUM_REQ-1:0] rrGrants[4];

      //          ep pid   zlp  len payload                  tog   gaps  drop  pid    const crc       ref
      vecs[0] = '{0, 4'h3, 1'b1, 0, 72'h0,                   1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 16'h0000, -1};
      vecs[1] = '{1, 4'hB, 1'b0, 4, 72'h03020100,            1'b0, 1'b0, 1'b0, 8'h4B, 1'b0, 16'h0000, -1};
      vecs[2] = '{1, 4'hB, 1'b0, 4, 72'h03020100,            1'b1, 1'b0, 1'b0, 8'h4B, 1'b0, 16'h0000,  1};
      vecs[3] = '{1, 4'hB, 1'b0, 4, 72'h03020100,            1'b0, 1'b1, 1'b0, 8'h4B, 1'b0, 16'h0000,  1};
      vecs[4] = '{0, 4'h1, 1'b0, 9, 72'h393837363534333231,  1'b0, 1'b0, 1'b1, 8'hE1, 1'b1, 16'hB4C8, -1};
      vecs[5] = '{0, 4'h9, 1'b0, 1, 72'hA5,                  1'b1, 1'b1, 1'b0, 8'h69, 1'b0, 16'h0000, -1};
      vecs[6] = '{0, 4'h6, 1'b0, 2, 72'h2120,                1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 16'h0000, -1};
      for (int i = 0; i < 7; i++) gotCrc[i] = 16'h0000;
      for (int i = 0; i < 4; i++) rrGrants[i] = '0;

      reset        = 1'b0;
      bus.req      = '0;
      bus.req_pid  = '0;
      bus.req_zlp  = '0;
      bus.in_data  = '0;
      bus.in_valid = '0;
      bus.in_last  = '0;
      bus.tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset tx_valid", 32'(bus.tx_valid), 32'd0);
      checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
      checkOutput("reset grant", 32'(bus.grant), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("reset done", 32'(bus.done), 32'd0);
      reset = 1'b1;

      for (int vi = 0; vi < 6; vi++) applyStimulus(vi);

      // Reset asserted while the second payload byte is on the bus
      @(negedge clk);
      bus.req = 2'b01; bus.req_pid = 8'h06; bus.req_zlp = '0; bus.tx_ready = 1'b1;
      ptr = 0; fired = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         bus.in_valid = {1'b0, (ptr < 8)};
         bus.in_data  = {8'h00, 8'h10 + 8'(ptr)};
         bus.in_last  = {1'b0, (ptr == 7)};
         #1;
         if (bus.in_ready[0] && bus.in_valid[0]) begin
            if (ptr == 1) begin
               reset = 1'b0;
               fired = 1'b1;
               break;
            end
            ptr++;
         end
         @(negedge clk);
      end
      checkOutput("midreset reached byte2", 32'(fired), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("midreset tx_valid", 32'(bus.tx_valid), 32'd0);
      checkOutput("midreset grant", 32'(bus.grant), 32'd0);
      checkOutput("midreset busy", 32'(bus.busy), 32'd0);
      checkOutput("midreset in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1; bus.req = '0; bus.in_valid = '0; bus.in_last = '0;
      applyStimulus(6);

      // Both endpoints requesting continuously from a fresh reset
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bus.req = 2'b11; bus.req_pid = 8'h52; bus.req_zlp = 2'b11; bus.in_valid = '0; bus.tx_ready = 1'b1;
      nGrants = 0; prevGrant = '0;
      for (int c = 0; c < 300 && nGrants < 4; c++) begin
         @(negedge clk);
         #1;
         if (bus.grant != '0 && prevGrant == '0) begin
            rrGrants[nGrants] = bus.grant;
            nGrants++;
         end
         prevGrant = bus.grant;
      end
      checkOutput("rr grant count", 32'(nGrants), 32'd4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("rr grant[%0d]", k), 32'(rrGrants[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      bus.req = '0;
      busyLow = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         #1;
         if (!bus.busy) begin
            busyLow = 1'b1;
            break;
         end
      end
      checkOutput("rr drains to idle", 32'(busyLow), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
